leddata_display: RTL and testbench
==================================

# leddata_display

Memory-mapped eight-digit seven-segment display peripheral; the responder for the LED-data I/O window decoded by the CPU's memory/IO address decoder (0xFFFFFD00–0xFFFFFD7F). It holds one control register per digit, written and read back by the CPU through the I/O chip select. It time-multiplexes the eight digits onto shared active-low anode/cathode pins at a fixed scan rate.

## Interface
- SCAN_DIV, 20000, clock cycles each digit stays lit; legal range 2..2^20
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- leddatactrl  input  1  chip select from address decoder (I/O access in 0xFFFFFDx0 window)
- iowrite  input  1  CPU I/O write strobe
- ioread  input  1  CPU I/O read strobe
- ledaddr  input  3  digit select = CPU address bits [6:4] (16-byte stride per digit)
- ledwdata  input  32  CPU write data; only [5:0] used
- ioread_data  output  16  readback to CPU read mux
- seg_an  output  8  digit anodes, active-low, bit i = digit i
- seg_cat  output  8  cathodes, active-low; [0]=a … [6]=g, [7]=dp

## Operation
- Digit register i (6 bits): [3:0] hex value, [4] dp on, [5] digit enable. Reset value 6'b000000 (all digits off).
- Write: on rising clock when leddatactrl=1 and iowrite=1, reg[ledaddr] <= ledwdata[5:0]; ledwdata[31:6] ignored. No write otherwise.
- Read (combinational): leddatactrl=1 and ioread=1 → ioread_data = {10'b0, reg[ledaddr]}; else 16'h0000.
- Simultaneous iowrite and ioread: write happens at the edge; ioread_data in that cycle shows the pre-write value.
- Scan counter cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 it returns to 0 and digit index idx (3 bits) increments, wrapping 7→0.
- Output generation, registered every cycle from current idx and reg[idx]:
  - enable=1: seg_an = ~(8'b1 << idx); seg_cat[6:0] = glyph of value; seg_cat[7] = ~dp.
  - enable=0: seg_an = 8'hFF, seg_cat = 8'hFF (slot blank, timing unchanged).
- Glyphs (standard hex, active-low, dp off): 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.

## Timing
- Reset asserted (any time, including mid-scan): immediately cnt=0, idx=0, all regs=0, seg_an=8'hFF, seg_cat=8'hFF; ioread_data follows combinational rule (0 regs → 16'h0000 when selected).
- After reset release: first edge registers outputs for idx=0; idx advances to 1 at the edge where cnt=SCAN_DIV-1, outputs reflect idx=1 one cycle later.
- Each digit slot is exactly SCAN_DIV cycles; full frame = 8×SCAN_DIV cycles.
- Write-to-pin latency: if ledaddr == idx, new pattern on pins 2 edges after write edge (write edge, then output register edge); otherwise visible in that digit's next slot.
- Readback latency: value written at edge N readable in cycle after N.
- Only one anode low at any cycle; never two.

## Test plan
- Reset: hold reset=0 mid-scan with nonzero regs → seg_an=FF, seg_cat=FF, ioread_data=0000 on read of every address; after release all slots blank.
- Write/display (SCAN_DIV=4): write ledaddr=3, ledwdata=32'h0000002A → during slot 3 seg_an=F7, seg_cat=88; all other slots FF/FF.
- DP and upper bits ignored: write ledaddr=0, ledwdata=32'hFFFFFF31 → reg0=6'h31; slot 0 seg_an=FE, seg_cat=79; readback 16'h0031.
- Scan wrap/timing: enable all digits with value 8 → anodes cycle FE,FD,…,7F, each held 4 cycles, then FE again; seg_cat=80 throughout.
- Strobe gating: iowrite=1 with leddatactrl=0, and leddatactrl=1 with iowrite=0 → no register change; ioread=1 with leddatactrl=0 → ioread_data=0000.
- Simultaneous read+write to ledaddr=5 (old 6'h21, new 6'h2F) → that cycle ioread_data=0021, next cycle 002F.

Source files
------------

// File: rtl/leddata_display.sv
// -----------------------------------------------------------------------------
// leddata_display
//   Memory-mapped eight-digit seven-segment display peripheral. It answers the
//   LED-data I/O window of the CPU address decoder, keeps one 6-bit control
//   register per digit and time-multiplexes the digits onto shared active-low
//   anode/cathode pins at a fixed scan rate.
//
//   Digit register layout: [3:0] hex value, [4] decimal point on,
//                          [5] digit enable.
//
// Ports
//   clock        system clock, all state on rising edge
//   reset        asynchronous active-low reset, clears all state
//   leddatactrl  chip select from the address decoder
//   iowrite      CPU I/O write strobe
//   ioread       CPU I/O read strobe
//   ledaddr      digit select (CPU address bits [6:4])
//   ledwdata     CPU write data, only [5:0] are stored
//   ioread_data  combinational readback of the selected digit register
//   seg_an       digit anodes, active-low, bit i = digit i
//   seg_cat      cathodes, active-low, [0]=a .. [6]=g, [7]=dp
//
// Parameter
//   SCAN_DIV     clock cycles each digit stays lit (2 .. 2**20)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// leddata_display_chk
//   Run-time properties of the pin outputs: at most one anode driven at any
//   time, and a blank slot always blanks the cathodes as well.
// -----------------------------------------------------------------------------
module leddata_display_chk (
  input logic       clock,
  input logic       reset,
  input logic [7:0] seg_an,
  input logic [7:0] seg_cat
);

  // Never two digits lit at once.
  a_one_anode: assert property (@(posedge clock) disable iff (!reset)
    $onehot0(~seg_an));

  // When no anode is driven the cathodes are released too.
  a_blank_cat: assert property (@(posedge clock) disable iff (!reset)
    (seg_an == 8'hFF) |-> (seg_cat == 8'hFF));

endmodule

module leddata_display #(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        leddatactrl,
  input  logic        iowrite,
  input  logic        ioread,
  input  logic [2:0]  ledaddr,
  input  logic [31:0] ledwdata,
  output logic [15:0] ioread_data,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  // Last count value of a digit slot; 20 bits cover the largest legal divider.
  localparam logic [19:0] CNT_LAST = 20'(SCAN_DIV - 1);

  // Digit register field positions.
  localparam int EN_BIT = 5;
  localparam int DP_BIT = 4;

  // ---------------------------------------------------------------------------
  // Standard hex glyphs, active-low segments g..a (decimal point not included).
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex_glyph(input logic [3:0] value);
    logic [6:0] glyph;
    case (value)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      4'hF:    glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
    return glyph;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [5:0]  digit_q [8];
  logic [5:0]  digit_d [8];
  logic [19:0] cnt_q;
  logic [19:0] cnt_d;
  logic [2:0]  idx_q;
  logic [2:0]  idx_d;
  logic [7:0]  seg_an_q;
  logic [7:0]  seg_an_d;
  logic [7:0]  seg_cat_q;
  logic [7:0]  seg_cat_d;

  logic        wr_en_s;
  logic        rd_en_s;
  logic [5:0]  cur_digit_s;

  // The upper write-data bits carry no register state.
  logic        unused_wdata_s;
  assign unused_wdata_s = ^ledwdata[31:6];

  assign wr_en_s     = leddatactrl & iowrite;
  assign rd_en_s     = leddatactrl & ioread;
  assign cur_digit_s = digit_q[idx_q];

  // Register file next state: one digit updated per selected write.
  always_comb begin
    digit_d = digit_q;
    if (wr_en_s) begin
      digit_d[ledaddr] = ledwdata[5:0];
    end else begin
      digit_d = digit_q;
    end
  end

  // Register file storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        digit_q[i] <= 6'b000000;
      end
    end else begin
      digit_q <= digit_d;
    end
  end

  // Readback shows the stored (pre-write) value, so a simultaneous read and
  // write returns the old contents during the write cycle.
  always_comb begin
    ioread_data = 16'h0000;
    if (rd_en_s) begin
      ioread_data = {10'b0000000000, digit_q[ledaddr]};
    end else begin
      ioread_data = 16'h0000;
    end
  end

  // Scan timing next state: slot counter, digit index advances on slot end.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = 20'd0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + 20'd1;
      idx_d = idx_q;
    end
  end

  // Scan timing storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= 20'd0;
      idx_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Pin pattern for the digit currently being scanned. A disabled digit keeps
  // its slot but drives nothing, so the frame timing does not depend on which
  // digits are enabled.
  always_comb begin
    seg_an_d  = 8'hFF;
    seg_cat_d = 8'hFF;
    if (cur_digit_s[EN_BIT]) begin
      seg_an_d  = ~(8'd1 << idx_q);
      seg_cat_d = {~cur_digit_s[DP_BIT], hex_glyph(cur_digit_s[3:0])};
    end else begin
      seg_an_d  = 8'hFF;
      seg_cat_d = 8'hFF;
    end
  end

  // Registered pin drivers; reset blanks the display immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg_an_q  <= 8'hFF;
      seg_cat_q <= 8'hFF;
    end else begin
      seg_an_q  <= seg_an_d;
      seg_cat_q <= seg_cat_d;
    end
  end

  assign seg_an  = seg_an_q;
  assign seg_cat = seg_cat_q;

  leddata_display_chk u_chk (
    .clock   (clock),
    .reset   (reset),
    .seg_an  (seg_an_q),
    .seg_cat (seg_cat_q)
  );

endmodule

// File: tb/tb_leddata_display.sv
module tb_leddata_display;

  localparam int SD = 4;

  logic        clock;
  logic        reset;
  logic        leddatactrl;
  logic        iowrite;
  logic        ioread;
  logic [2:0]  ledaddr;
  logic [31:0] ledwdata;
  logic [15:0] ioread_data;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  int n_checks;
  int n_errors;
  int edge_cnt;

  logic [5:0] model_reg [8];
  logic [7:0] glyph_tab [16];

  leddata_display #(.SCAN_DIV(SD)) dut (
    .clock       (clock),
    .reset       (reset),
    .leddatactrl (leddatactrl),
    .iowrite     (iowrite),
    .ioread      (ioread),
    .ledaddr     (ledaddr),
    .ledwdata    (ledwdata),
    .ioread_data (ioread_data),
    .seg_an      (seg_an),
    .seg_cat     (seg_cat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edges since reset release; the outputs seen after edge k belong to slot (k-1)/SD.
  always @(posedge clock or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] slot_now();
    return 3'(((edge_cnt - 1) / SD) % 8);
  endfunction

  // One bus cycle starting at a negedge, ending at the next negedge.
  task automatic bus(input logic ctrl, input logic wr, input logic [2:0] a, input logic [31:0] d);
    leddatactrl = ctrl; iowrite = wr; ioread = 1'b0; ledaddr = a; ledwdata = d;
    @(negedge clock);
    leddatactrl = 1'b0; iowrite = 1'b0; ledwdata = 32'h0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    bus(1'b1, 1'b1, a, d);
    model_reg[a] = d[5:0];
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    leddatactrl = 1'b1; ioread = 1'b1; ledaddr = a;
    #1;
    check_val(tag, 32'(ioread_data), 32'(exp));
    leddatactrl = 1'b0; ioread = 1'b0;
  endtask

  // Check a full frame against the register model and the scan position.
  task automatic check_frame(input string tag);
    logic [2:0] ix;
    logic [5:0] r;
    logic [7:0] ea;
    logic [7:0] ec;
    @(negedge clock);
    for (int c = 0; c < 8 * SD; c++) begin
      ix = slot_now();
      r  = model_reg[ix];
      if (r[5]) begin
        ea = 8'hFF;
        ea[ix] = 1'b0;
        ec = {~r[4], glyph_tab[r[3:0]][6:0]};
      end else begin
        ea = 8'hFF;
        ec = 8'hFF;
      end
      check_val({tag, "_an"}, 32'(seg_an), 32'(ea));
      check_val({tag, "_cat"}, 32'(seg_cat), 32'(ec));
      @(negedge clock);
    end
  endtask

  // Advance to the first negedge whose outputs belong to slot s (bounded).
  task automatic wait_slot(input logic [2:0] s);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 10 * SD && !found; c++) begin
      @(negedge clock);
      if (edge_cnt >= 1 && slot_now() == s) found = 1'b1;
    end
    check_val("wait_slot_timeout", 32'(found), 32'd1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    glyph_tab[0]  = 8'hC0; glyph_tab[1]  = 8'hF9; glyph_tab[2]  = 8'hA4; glyph_tab[3]  = 8'hB0;
    glyph_tab[4]  = 8'h99; glyph_tab[5]  = 8'h92; glyph_tab[6]  = 8'h82; glyph_tab[7]  = 8'hF8;
    glyph_tab[8]  = 8'h80; glyph_tab[9]  = 8'h90; glyph_tab[10] = 8'h88; glyph_tab[11] = 8'h83;
    glyph_tab[12] = 8'hC6; glyph_tab[13] = 8'hA1; glyph_tab[14] = 8'h86; glyph_tab[15] = 8'h8E;
    for (int i = 0; i < 8; i++) model_reg[i] = 6'h00;

    reset = 1'b0; leddatactrl = 1'b0; iowrite = 1'b0; ioread = 1'b0;
    ledaddr = 3'd0; ledwdata = 32'h0;
    repeat (3) @(negedge clock);
    check_val("rst_an", 32'(seg_an), 32'h0000_00FF);
    check_val("rst_cat", 32'(seg_cat), 32'h0000_00FF);
    rd_check("rst_rd0", 3'd0, 16'h0000);

    // Release and confirm every slot is blank.
    reset = 1'b1;
    check_frame("blank");

    // Digit 3 shows 'A', no dp.
    wr_reg(3'd3, 32'h0000_002A);
    rd_check("rd3", 3'd3, 16'h002A);
    wait_slot(3'd3);
    check_val("slot3_an", 32'(seg_an), 32'h0000_00F7);
    check_val("slot3_cat", 32'(seg_cat), 32'h0000_0088);
    check_frame("d3");

    // Upper write bits ignored, dp on.
    wr_reg(3'd0, 32'hFFFF_FF31);
    rd_check("rd0_dp", 3'd0, 16'h0031);
    wait_slot(3'd0);
    check_val("slot0_an", 32'(seg_an), 32'h0000_00FE);
    check_val("slot0_cat", 32'(seg_cat), 32'h0000_0079);

    // Strobe gating.
    bus(1'b0, 1'b1, 3'd1, 32'h0000_003F);
    bus(1'b1, 1'b0, 3'd1, 32'h0000_003F);
    rd_check("gate_wr", 3'd1, 16'h0000);
    leddatactrl = 1'b0; ioread = 1'b1; ledaddr = 3'd3;
    #1;
    check_val("gate_rd", 32'(ioread_data), 32'h0);
    ioread = 1'b0;

    // Simultaneous read and write.
    wr_reg(3'd5, 32'h0000_0021);
    leddatactrl = 1'b1; iowrite = 1'b1; ioread = 1'b1; ledaddr = 3'd5; ledwdata = 32'h0000_002F;
    #1;
    check_val("rdwr_old", 32'(ioread_data), 32'h0000_0021);
    @(negedge clock);
    iowrite = 1'b0;
    #1;
    check_val("rdwr_new", 32'(ioread_data), 32'h0000_002F);
    leddatactrl = 1'b0; ioread = 1'b0; ledwdata = 32'h0;
    model_reg[5] = 6'h2F;
    check_frame("mix");

    // All digits show 8: anodes walk FE..7F, four cycles each.
    for (int i = 0; i < 8; i++) wr_reg(3'(i), 32'h0000_0028);
    check_frame("all8");

    // Reset mid-scan with populated registers.
    wait_slot(3'd2);
    reset = 1'b0;
    #1;
    check_val("mid_rst_an", 32'(seg_an), 32'h0000_00FF);
    check_val("mid_rst_cat", 32'(seg_cat), 32'h0000_00FF);
    for (int i = 0; i < 8; i++) rd_check("mid_rst_rd", 3'(i), 16'h0000);
    for (int i = 0; i < 8; i++) model_reg[i] = 6'h00;
    @(negedge clock);
    reset = 1'b1;
    check_frame("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
